// File: rtl/vscale_pc_redirect_ctrl_if.sv
// Signal bundle between the pipeline (redirect requests, fetch stall) and the
// PC redirect sequencer (PC mux select, kill and hold controls).
interface vscale_pc_redirect_ctrl_if;
    logic       imem_wait;
    logic       stall_DX;
    logic       trap_req;
    logic       jalr_DX;
    logic       jal_DX;
    logic       branch_taken_DX;
    logic [2:0] PC_src_sel;
    logic       kill_IF;
    logic       kill_DX;
    logic       hold_DX;
    logic       redirect_pending;

    modport master (
        output imem_wait, stall_DX, trap_req, jalr_DX, jal_DX, branch_taken_DX,
        input  PC_src_sel, kill_IF, kill_DX, hold_DX, redirect_pending
    );

    modport slave (
        input  imem_wait, stall_DX, trap_req, jalr_DX, jal_DX, branch_taken_DX,
        output PC_src_sel, kill_IF, kill_DX, hold_DX, redirect_pending
    );
endinterface

// File: rtl/vscale_pc_redirect_ctrl.sv
// Fetch PC-select sequencer: boot replay, fixed-priority redirect arbitration,
// and holding of a redirect while instruction memory is busy.
module vscale_pc_redirect_ctrl #(
    parameter int unsigned BOOT_CYCLES = 2
) (
    input logic                      clk,
    input logic                      reset_n,
    vscale_pc_redirect_ctrl_if.slave bus
);

    localparam logic [2:0] SEL_PLUS_FOUR     = 3'd0;
    localparam logic [2:0] SEL_BRANCH_TARGET = 3'd1;
    localparam logic [2:0] SEL_JAL_TARGET    = 3'd2;
    localparam logic [2:0] SEL_REG_TARGET    = 3'd3;
    localparam logic [2:0] SEL_REPLAY        = 3'd4;
    localparam logic [2:0] SEL_STVEC         = 3'd5;
    localparam logic [3:0] BOOT_INIT         = 4'(BOOT_CYCLES - 1);
    localparam int         NUM_REQ           = 5;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] pend_sel_reg, pend_sel_next;
    logic [3:0] boot_cnt_reg, boot_cnt_next;

    logic [2:0] pc_src_sel;
    logic       kill_if;
    logic       kill_dx;
    logic       hold_dx;
    logic       pending;

    // Request vector ordered highest priority first (bit 0 = trap).
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [2:0]         run_sel;

    assign req = {bus.stall_DX, bus.branch_taken_DX, bus.jal_DX, bus.jalr_DX, bus.trap_req};

    function automatic logic [2:0] req_code(input int idx);
        logic [2:0] code;
        case (idx)
            0:       code = SEL_STVEC;
            1:       code = SEL_REG_TARGET;
            2:       code = SEL_JAL_TARGET;
            3:       code = SEL_BRANCH_TARGET;
            4:       code = SEL_REPLAY;
            default: code = SEL_PLUS_FOUR;
        endcase
        return code;
    endfunction

    function automatic logic is_redirect(input logic [2:0] sel);
        return (sel == SEL_BRANCH_TARGET) || (sel == SEL_JAL_TARGET) ||
               (sel == SEL_REG_TARGET)    || (sel == SEL_STVEC);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_prio
            if (gi == 0) begin : g_top
                assign grant[gi] = req[gi];
            end else begin : g_rest
                assign grant[gi] = req[gi] & ~(|req[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        run_sel = SEL_PLUS_FOUR;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                run_sel = req_code(i);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        pend_sel_next = pend_sel_reg;
        boot_cnt_next = boot_cnt_reg;
        pc_src_sel    = SEL_REPLAY;
        kill_if       = 1'b1;
        kill_dx       = 1'b1;
        hold_dx       = 1'b0;
        pending       = 1'b0;

        case (state_reg)
            ST_BOOT: begin
                if (boot_cnt_reg == 4'd0) begin
                    state_next = ST_RUN;
                end else begin
                    boot_cnt_next = boot_cnt_reg - 4'd1;
                end
            end

            ST_RUN: begin
                pc_src_sel = run_sel;
                kill_if    = is_redirect(run_sel);
                kill_dx    = grant[0];
                // Replay/sequential selects with imem_wait simply re-present
                // next cycle; only real redirects need to be remembered.
                if (is_redirect(run_sel) && bus.imem_wait) begin
                    pend_sel_next = run_sel;
                    state_next    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                pending = 1'b1;
                if (bus.trap_req && (pend_sel_reg != SEL_STVEC)) begin
                    // A trap pre-empts the held DX redirect, so DX is
                    // squashed rather than held.
                    pc_src_sel = SEL_STVEC;
                    kill_dx    = 1'b1;
                    hold_dx    = 1'b0;
                    if (bus.imem_wait) begin
                        pend_sel_next = SEL_STVEC;
                    end else begin
                        state_next = ST_RUN;
                    end
                end else begin
                    pc_src_sel = pend_sel_reg;
                    kill_dx    = (pend_sel_reg == SEL_STVEC);
                    hold_dx    = (pend_sel_reg == SEL_BRANCH_TARGET) ||
                                 (pend_sel_reg == SEL_JAL_TARGET)    ||
                                 (pend_sel_reg == SEL_REG_TARGET);
                    if (!bus.imem_wait) begin
                        state_next = ST_RUN;
                    end
                end
            end

            default: begin
                state_next = ST_BOOT;
            end
        endcase

        if (!reset_n) begin
            pc_src_sel = SEL_REPLAY;
            kill_if    = 1'b1;
            kill_dx    = 1'b1;
            hold_dx    = 1'b0;
            pending    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_BOOT;
            pend_sel_reg <= SEL_REPLAY;
            boot_cnt_reg <= BOOT_INIT;
        end else begin
            state_reg    <= state_next;
            pend_sel_reg <= pend_sel_next;
            boot_cnt_reg <= boot_cnt_next;
        end
    end

    assign bus.PC_src_sel       = pc_src_sel;
    assign bus.kill_IF          = kill_if;
    assign bus.kill_DX          = kill_dx;
    assign bus.hold_DX          = hold_dx;
    assign bus.redirect_pending = pending;

endmodule

// File: tb/tb_vscale_pc_redirect_ctrl.sv
// Directed bench for the PC redirect sequencer; expected outputs are queued
// with each stimulus step and checked against the DUT half a cycle later.
module tb_vscale_pc_redirect_ctrl;

    logic clk;
    logic reset_n;

    vscale_pc_redirect_ctrl_if bus ();

    vscale_pc_redirect_ctrl #(.BOOT_CYCLES(2)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic       kill_if;
        logic       kill_dx;
        logic       hold_dx;
        logic       pend;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    tests_run;
    int    tests_failed;

    task automatic check(input string tag, input string field,
                         input logic [2:0] obs, input logic [2:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, expv);
        end
    endtask

    // One cycle: drive inputs just after the edge, queue the expected outputs,
    // then compare on the falling edge before the next state update.
    task automatic step(input string tag, input logic rst_n, input logic iw,
                        input logic st, input logic tr, input logic jr,
                        input logic jl, input logic br,
                        input logic [2:0] e_sel, input logic e_kif,
                        input logic e_kdx, input logic e_hold, input logic e_pend);
        exp_t e;
        exp_t got;
        string t;
        @(posedge clk);
        #1;
        reset_n             = rst_n;
        bus.imem_wait       = iw;
        bus.stall_DX        = st;
        bus.trap_req        = tr;
        bus.jalr_DX         = jr;
        bus.jal_DX          = jl;
        bus.branch_taken_DX = br;
        e.sel = e_sel; e.kill_if = e_kif; e.kill_dx = e_kdx;
        e.hold_dx = e_hold; e.pend = e_pend;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        got = exp_q.pop_front();
        t   = tag_q.pop_front();
        check(t, "sel",  bus.PC_src_sel,               got.sel);
        check(t, "kif",  {2'b00, bus.kill_IF},          {2'b00, got.kill_if});
        check(t, "kdx",  {2'b00, bus.kill_DX},          {2'b00, got.kill_dx});
        check(t, "hold", {2'b00, bus.hold_DX},          {2'b00, got.hold_dx});
        check(t, "pend", {2'b00, bus.redirect_pending}, {2'b00, got.pend});
        $display("[TB] %-12s rst_n=%0b iw=%0b st=%0b tr=%0b jr=%0b jl=%0b br=%0b -> sel=%0d kif=%0b kdx=%0b hold=%0b pend=%0b",
                 t, rst_n, iw, st, tr, jr, jl, br, bus.PC_src_sel, bus.kill_IF,
                 bus.kill_DX, bus.hold_DX, bus.redirect_pending);
    endtask

    initial begin
        tests_run           = 0;
        tests_failed        = 0;
        reset_n             = 1'b0;
        bus.imem_wait       = 1'b0;
        bus.stall_DX        = 1'b0;
        bus.trap_req        = 1'b0;
        bus.jalr_DX         = 1'b0;
        bus.jal_DX          = 1'b0;
        bus.branch_taken_DX = 1'b0;

        //    tag            rst iw st tr jr jl br   sel kif kdx hold pend
        step("reset0",       0, 1, 0, 0, 0, 1, 0,   4,  1,  1,  0,  0);
        step("reset1",       0, 0, 0, 1, 0, 0, 0,   4,  1,  1,  0,  0);
        // BOOT ignores requests and is not extended by imem_wait
        step("boot1",        1, 1, 0, 1, 0, 0, 0,   4,  1,  1,  0,  0);
        step("boot2",        1, 1, 0, 0, 1, 0, 0,   4,  1,  1,  0,  0);
        step("run_idle",     1, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0,  0);
        // simultaneous requests: trap wins
        step("trap_multi",   1, 0, 0, 1, 1, 0, 1,   5,  1,  1,  0,  0);
        step("after_trap",   1, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0,  0);
        step("jalr_jal",     1, 0, 0, 0, 1, 1, 0,   3,  1,  0,  0,  0);
        step("jal_br_st",    1, 0, 1, 0, 0, 1, 1,   2,  1,  0,  0,  0);
        step("branch",       1, 0, 0, 0, 0, 0, 1,   1,  1,  0,  0,  0);
        step("br_stall",     1, 0, 1, 0, 0, 0, 1,   1,  1,  0,  0,  0);
        step("quiet",        1, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0,  0);
        // jal held across three busy cycles
        step("jal_w1",       1, 1, 0, 0, 0, 1, 0,   2,  1,  0,  0,  0);
        step("jal_w2",       1, 1, 0, 0, 0, 1, 0,   2,  1,  0,  1,  1);
        step("jal_w3",       1, 1, 0, 0, 1, 0, 1,   2,  1,  0,  1,  1);
        step("jal_w4",       1, 0, 0, 0, 0, 0, 0,   2,  1,  0,  1,  1);
        step("jal_done",     1, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0,  0);
        // stall with busy memory is not a pending redirect
        step("stall_w1",     1, 1, 1, 0, 0, 0, 0,   4,  0,  0,  0,  0);
        step("stall_w2",     1, 1, 1, 0, 0, 0, 0,   4,  0,  0,  0,  0);
        step("idle_w",       1, 1, 0, 0, 0, 0, 0,   0,  0,  0,  0,  0);
        step("stall_free",   1, 0, 1, 0, 0, 0, 0,   4,  0,  0,  0,  0);
        // branch pending, trap pre-empts and stays pending as stvec
        step("br_w1",        1, 1, 0, 0, 0, 0, 1,   1,  1,  0,  0,  0);
        step("br_w2",        1, 1, 0, 0, 0, 0, 0,   1,  1,  0,  1,  1);
        step("br_trap",      1, 1, 0, 1, 0, 0, 0,   5,  1,  1,  0,  1);
        step("stvec_w1",     1, 1, 0, 0, 0, 0, 0,   5,  1,  1,  0,  1);
        step("stvec_w2",     1, 1, 0, 0, 1, 0, 0,   5,  1,  1,  0,  1);
        step("stvec_w3",     1, 0, 0, 0, 0, 0, 0,   5,  1,  1,  0,  1);
        step("stvec_done",   1, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0,  0);
        // trap in WAIT with memory free completes at once
        step("br2_w1",       1, 1, 0, 0, 0, 0, 1,   1,  1,  0,  0,  0);
        step("br2_trap",     1, 0, 0, 1, 0, 0, 0,   5,  1,  1,  0,  1);
        step("br2_done",     1, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0,  0);
        // trap itself pending; a second trap does not alter it
        step("trap_w1",      1, 1, 0, 1, 0, 0, 0,   5,  1,  1,  0,  0);
        step("trap_w2",      1, 1, 0, 1, 0, 0, 0,   5,  1,  1,  0,  1);
        step("trap_w3",      1, 0, 0, 0, 0, 0, 0,   5,  1,  1,  0,  1);
        step("trap_done",    1, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0,  0);
        // reset in the middle of a pending jalr
        step("jalr_w1",      1, 1, 0, 0, 1, 0, 0,   3,  1,  0,  0,  0);
        step("jalr_w2",      1, 1, 0, 0, 0, 0, 0,   3,  1,  0,  1,  1);
        step("mid_reset",    0, 1, 0, 0, 0, 0, 0,   4,  1,  1,  0,  0);
        step("reboot1",      1, 1, 0, 0, 1, 0, 0,   4,  1,  1,  0,  0);
        step("reboot2",      1, 0, 0, 0, 0, 0, 0,   4,  1,  1,  0,  0);
        step("rerun",        1, 1, 0, 0, 0, 0, 0,   0,  0,  0,  0,  0);
        step("rerun_br",     1, 0, 0, 0, 0, 0, 1,   1,  1,  0,  0,  0);

        tests_run++;
        assert (exp_q.size() === 0) else begin
            tests_failed++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
